ioctl_download_master: RTL and testbench
========================================

// Module: ioctl_download_master
// PURPOSE
//  Initiator side of the ioctl download interface for AUP-ZU3 builds, where no ARM HPS exists to push ROMs.
//  Accepts a download command plus a byte stream from the PS/DMA side and drives the core's ioctl_* inputs.
//  Emits the same download/wr/addr/dout sequence the MiSTer framework produces, including ioctl_wait flow control.
//  Sits beside hps_io, between the PS-fed byte FIFO and emu's ioctl_* ports.
// PARAMETERS
//  WIDE      0  0: one byte per ioctl_wr, addr +1; 1: 16-bit little-endian word per ioctl_wr, addr +2
//  SETUP_CYC 4  cycles ioctl_download is high before the first byte fetch (1..255)
//  WR_GAP    1  idle cycles after each ioctl_wr before the next fetch (0..255)
//  TAIL_CYC  4  cycles ioctl_download stays high after the last write (1..255)
// PORTS
//  clk_sys        in   1      system clock; all logic is in this domain
//  reset_n        in   1      asynchronous reset, active low
//  cmd_start      in   1      1-cycle request to begin a download; ignored while busy
//  cmd_index      in   16     index latched on an accepted cmd_start
//  cmd_ext        in   32     file extension latched on an accepted cmd_start
//  abort          in   1      terminate the current download immediately
//  s_valid        in   1      stream byte valid
//  s_ready        out  1      stream byte accepted when s_valid & s_ready
//  s_data         in   8      stream byte
//  s_last         in   1      marks the final byte of the file
//  ioctl_download out  1      download window
//  ioctl_index    out  16     latched cmd_index
//  ioctl_file_ext out  32     latched cmd_ext
//  ioctl_wr       out  1      one-cycle write strobe
//  ioctl_addr     out  27     write address
//  ioctl_dout     out  W      write data; W = WIDE?16:8
//  ioctl_wait     in   1      core backpressure; no ioctl_wr is issued while high
//  busy           out  1      high in every state except IDLE
//  done           out  1      1-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: all outputs 0, including s_ready, ioctl_* and busy; state IDLE. Asserting reset_n low mid-download drops everything at once.
//  States: IDLE -> SETUP -> FETCH -> WRITE -> GAP -> (FETCH | TAIL) -> IDLE.
//  IDLE: a cmd_start latches index and ext; on the next edge download=1, busy=1, addr=0, state SETUP.
//  SETUP: counts SETUP_CYC cycles, then enters FETCH.
//  FETCH: s_ready=1 and all other outputs are registered.
//    WIDE=0: the first handshake loads dout=s_data and moves to WRITE.
//    WIDE=1: the first byte goes to dout[7:0] and the second to dout[15:8], then WRITE.
//    WIDE=1 with s_last on the first byte: dout[15:8]=0, then WRITE.
//  Latched s_last selects the exit from GAP.
//  WRITE: s_ready=0. If ioctl_wait is low at an edge, ioctl_wr=1 for exactly one cycle; addr and dout stay stable in that cycle.
//    If ioctl_wait is high, the block holds with wr=0. A wait rising during the wr cycle does not cancel that write.
//  After the wr cycle, addr advances by 1 (WIDE=0) or 2 (WIDE=1), and the block enters GAP.
//  GAP: waits WR_GAP cycles (0 = skip), then goes to TAIL if last was latched, otherwise FETCH.
//  TAIL: download stays high for TAIL_CYC cycles. On the edge that clears download, done=1 for one cycle, busy=0, state IDLE.
//  ioctl_addr is held after completion until the next cmd_start.
//  ioctl_addr wraps modulo 2^27; the wrap is silent and the download continues.
//  abort in any non-IDLE state: on the next edge download=0, wr=0, s_ready=0, state IDLE, with no done.
//    A wr already in flight that cycle completes. abort has priority over cmd_start.
//  cmd_start while busy: ignored, and latched index/ext do not change.
//  Zero-byte file is impossible: s_last always accompanies a real byte.
// TESTING
//  WIDE=0: start idx=0x0001, bytes 11 22 33(last), wait=0 -> 3 wr pulses, addr 0,1,2, dout 11,22,33, one done.
//  WIDE=1: bytes AA BB CC(last) -> wr addr0 dout 0xBBAA, addr2 dout 0x00CC, then done.
//  ioctl_wait high 10 cycles at WRITE -> no wr during wait; wr exactly one cycle after wait falls; no byte lost.
//  abort after 2nd byte -> next edge download=0, busy=0, no done; new cmd_start restarts at addr 0.
//  cmd_start (idx=5) while busy on idx=2 -> ioctl_index stays 2 through done.
//  s_valid gaps / reset_n low mid-WRITE -> stalls in FETCH; reset gives all outputs 0 asynchronously.

Source files
------------

// File: rtl/ioctl_download_master.sv
// Initiator side of the ioctl download interface: turns a PS-fed byte stream into the
// ioctl_download/wr/addr/dout sequence a core expects, honouring ioctl_wait backpressure.
//
// state  | meaning
// IDLE   | no download; waiting for cmd_start
// SETUP  | download window open, counting SETUP_CYC before the first fetch
// FETCH  | s_ready high, collecting one byte (WIDE=0) or two bytes (WIDE=1)
// WRITE  | holding addr/dout; strobes ioctl_wr once ioctl_wait is low
// GAP    | WR_GAP idle cycles after a write
// TAIL   | download window held TAIL_CYC cycles after the final write
module ioctl_download_master #(
    parameter int WIDE      = 0,
    parameter int SETUP_CYC = 4,
    parameter int WR_GAP    = 1,
    parameter int TAIL_CYC  = 4,
    localparam int DW       = (WIDE != 0) ? 16 : 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cmd_start,
    input  logic [15:0]   cmd_index,
    input  logic [31:0]   cmd_ext,
    input  logic          abort,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          ioctl_download,
    output logic [15:0]   ioctl_index,
    output logic [31:0]   ioctl_file_ext,
    output logic          ioctl_wr,
    output logic [26:0]   ioctl_addr,
    output logic [DW-1:0] ioctl_dout,
    input  logic          ioctl_wait,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FETCH,
        S_WRITE,
        S_GAP,
        S_TAIL
    } state_t;

    localparam logic [7:0]  SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  GAP_LOAD   = 8'(WR_GAP - 1);
    localparam logic [7:0]  TAIL_LOAD  = 8'(TAIL_CYC - 1);
    localparam logic [26:0] ADDR_STEP  = (WIDE != 0) ? 27'd2 : 27'd1;

    state_t     state;
    logic [7:0] cnt;
    logic       hi_phase;
    logic       last_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= 8'd0;
            hi_phase       <= 1'b0;
            last_q         <= 1'b0;
            s_ready        <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_index    <= 16'd0;
            ioctl_file_ext <= 32'd0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= 27'd0;
            ioctl_dout     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                // a strobe already on the bus this cycle still lands; nothing new follows
                state          <= S_IDLE;
                ioctl_download <= 1'b0;
                ioctl_wr       <= 1'b0;
                s_ready        <= 1'b0;
                busy           <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (cmd_start) begin
                            ioctl_index    <= cmd_index;
                            ioctl_file_ext <= cmd_ext;
                            ioctl_download <= 1'b1;
                            busy           <= 1'b1;
                            ioctl_addr     <= 27'd0;
                            cnt            <= SETUP_LOAD;
                            hi_phase       <= 1'b0;
                            last_q         <= 1'b0;
                            state          <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (cnt == 8'd0) begin
                            s_ready <= 1'b1;
                            state   <= S_FETCH;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    S_FETCH: begin
                        if (s_valid && s_ready) begin
                            if (WIDE != 0 && hi_phase) begin
                                ioctl_dout[DW-1 -: 8] <= s_data;
                                last_q                <= s_last;
                                hi_phase              <= 1'b0;
                                s_ready               <= 1'b0;
                                state                 <= S_WRITE;
                            end else if (WIDE != 0 && !s_last) begin
                                ioctl_dout[7:0] <= s_data;
                                hi_phase        <= 1'b1;
                            end else begin
                                // odd final byte of a wide file leaves the upper lane zero
                                if (WIDE != 0) ioctl_dout[DW-1 -: 8] <= 8'h00;
                                ioctl_dout[7:0] <= s_data;
                                last_q          <= s_last;
                                s_ready         <= 1'b0;
                                state           <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (ioctl_wr) begin
                            ioctl_wr   <= 1'b0;
                            ioctl_addr <= ioctl_addr + ADDR_STEP;
                            if (WR_GAP != 0) begin
                                cnt   <= GAP_LOAD;
                                state <= S_GAP;
                            end else if (last_q) begin
                                cnt   <= TAIL_LOAD;
                                state <= S_TAIL;
                            end else begin
                                s_ready <= 1'b1;
                                state   <= S_FETCH;
                            end
                        end else if (!ioctl_wait) begin
                            ioctl_wr <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else if (last_q) begin
                            cnt   <= TAIL_LOAD;
                            state <= S_TAIL;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                    S_TAIL: begin
                        if (cnt == 8'd0) begin
                            ioctl_download <= 1'b0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ioctl_download_master.sv
// Bench for ioctl_download_master: a byte-wide and a word-wide instance fed the same files,
// with a scoreboard of expected (addr, data) writes built from the file contents.
module tb_ioctl_download_master;

    localparam int SETUP = 3;
    localparam int GAP   = 2;
    localparam int TAIL  = 5;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [15:0] cmd_index = 16'd0;
    logic [31:0] cmd_ext = 32'd0;
    logic        abort = 1'b0;
    logic        ioctl_wait = 1'b0;

    logic        s_valid0 = 1'b0, s_last0 = 1'b0;
    logic [7:0]  s_data0 = 8'd0;
    logic        s_valid1 = 1'b0, s_last1 = 1'b0;
    logic [7:0]  s_data1 = 8'd0;

    logic        s_ready0, dl0, wr0, busy0, done0;
    logic [15:0] idx0;
    logic [31:0] ext0;
    logic [26:0] addr0;
    logic [7:0]  dout0;
    logic        s_ready1, dl1, wr1, busy1, done1;
    logic [15:0] idx1;
    logic [31:0] ext1;
    logic [26:0] addr1;
    logic [15:0] dout1;

    ioctl_download_master #(.WIDE(0), .SETUP_CYC(SETUP), .WR_GAP(GAP), .TAIL_CYC(TAIL)) u_byte (
        .clk_sys(clk_sys), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_ext(cmd_ext), .abort(abort), .s_valid(s_valid0), .s_ready(s_ready0),
        .s_data(s_data0), .s_last(s_last0), .ioctl_download(dl0), .ioctl_index(idx0),
        .ioctl_file_ext(ext0), .ioctl_wr(wr0), .ioctl_addr(addr0), .ioctl_dout(dout0),
        .ioctl_wait(ioctl_wait), .busy(busy0), .done(done0));

    ioctl_download_master #(.WIDE(1), .SETUP_CYC(SETUP), .WR_GAP(GAP), .TAIL_CYC(TAIL)) u_word (
        .clk_sys(clk_sys), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_ext(cmd_ext), .abort(abort), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_data(s_data1), .s_last(s_last1), .ioctl_download(dl1), .ioctl_index(idx1),
        .ioctl_file_ext(ext1), .ioctl_wr(wr1), .ioctl_addr(addr1), .ioctl_dout(dout1),
        .ioctl_wait(ioctl_wait), .busy(busy1), .done(done1));

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  file_q[$];
    logic [7:0]  q0[$], q1[$];
    logic [42:0] exp0[$], exp1[$];
    int          wait_mode = 0;
    logic        wait_q = 1'b0;
    logic [15:0] exp_idx;
    logic [31:0] exp_ext;
    int          exp_n;
    int          d_base0, d_base1;

    bit wr_prev[2];
    bit seen_ready[2];
    int setup_cnt[2];
    int tail_cnt[2];
    int n_wr[2];
    int n_done[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // stream source: pops on accepted handshakes, re-presents at the falling edge
    always @(posedge clk_sys) begin
        wait_q <= ioctl_wait;
        if (s_valid0 && s_ready0 && q0.size() > 0) void'(q0.pop_front());
        if (s_valid1 && s_ready1 && q1.size() > 0) void'(q1.pop_front());
    end

    always @(negedge clk_sys) begin
        s_valid0 = (q0.size() > 0) && ($urandom_range(3) != 0);
        s_data0  = (q0.size() > 0) ? q0[0] : 8'($urandom);
        s_last0  = (q0.size() == 1);
        s_valid1 = (q1.size() > 0) && ($urandom_range(3) != 0);
        s_data1  = (q1.size() > 0) ? q1[0] : 8'($urandom);
        s_last1  = (q1.size() == 1);
        ioctl_wait = (wait_mode == 1) ? ($urandom_range(2) == 0) : (wait_mode == 2);
    end

    task automatic mon(input int k, input logic wr, input logic [26:0] addr, input logic [15:0] dout,
                       input logic dl, input logic sr, input logic bsy, input logic dn);
        logic [42:0] e;
        if (wr) begin
            chk("wr_single", wr_prev[k], 0);
            if (!wr_prev[k]) chk("wr_vs_wait", wait_q, 0);
            n_wr[k]++;
            tail_cnt[k] = 0;
            if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
                chk("wr_extra", 1, 0);
            end else begin
                e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                chk("wr_addr", addr, e[42:16]);
                chk("wr_data", dout, e[15:0]);
            end
        end else if (dl) begin
            tail_cnt[k]++;
        end
        if (!dl) begin
            seen_ready[k] = 0;
            setup_cnt[k] = 0;
        end else if (!seen_ready[k]) begin
            if (sr) begin
                chk("setup_len", setup_cnt[k], SETUP);
                seen_ready[k] = 1;
            end else begin
                setup_cnt[k]++;
            end
        end
        if (dn) begin
            n_done[k]++;
            chk("done_dl", dl, 0);
            chk("done_busy", bsy, 0);
            chk("tail_len", tail_cnt[k], GAP + TAIL);
        end
        wr_prev[k] = wr;
    endtask

    always @(negedge clk_sys) begin
        if (reset_n) begin
            mon(0, wr0, addr0, {8'h00, dout0}, dl0, s_ready0, busy0, done0);
            mon(1, wr1, addr1, dout1, dl1, s_ready1, busy1, done1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    task automatic fill_random(input int n);
        file_q.delete();
        for (int i = 0; i < n; i++) file_q.push_back(8'($urandom));
    endtask

    task automatic start_file(input logic [15:0] idx, input int wmode);
        int n;
        logic [31:0] ext;
        n = file_q.size();
        for (int i = 0; i < n; i++) begin
            q0.push_back(file_q[i]);
            q1.push_back(file_q[i]);
            exp0.push_back({27'(i), 8'h00, file_q[i]});
        end
        for (int i = 0; i < n; i += 2)
            exp1.push_back({27'(i), ((i + 1 < n) ? file_q[i + 1] : 8'h00), file_q[i]});
        ext = $urandom;
        cmd_index = idx;
        cmd_ext = ext;
        exp_idx = idx;
        exp_ext = ext;
        exp_n = n;
        d_base0 = n_done[0];
        d_base1 = n_done[1];
        wait_mode = wmode;
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic finish_file();
        int c;
        c = 0;
        while (c < 5000 && !(n_done[0] > d_base0 && n_done[1] > d_base1)) begin
            tick(1);
            c++;
        end
        chk("complete", (n_done[0] > d_base0 && n_done[1] > d_base1), 1);
        tick(2);
        chk("done_cnt0", n_done[0] - d_base0, 1);
        chk("done_cnt1", n_done[1] - d_base1, 1);
        chk("exp_left0", exp0.size(), 0);
        chk("exp_left1", exp1.size(), 0);
        chk("bytes_left", q0.size() + q1.size(), 0);
        chk("index0", idx0, exp_idx);
        chk("index1", idx1, exp_idx);
        chk("ext0", ext0, exp_ext);
        chk("ext1", ext1, exp_ext);
        chk("end_addr0", addr0, exp_n);
        chk("end_addr1", addr1, 2 * ((exp_n + 1) / 2));
        chk("end_idle", {dl0, dl1, busy0, busy1}, 0);
        wait_mode = 0;
        clear_all();
    endtask

    task automatic check_zero();
        chk("rz_ctl0", {s_ready0, dl0, wr0, busy0, done0}, 0);
        chk("rz_dat0", {idx0, addr0, dout0}, 0);
        chk("rz_ext0", ext0, 0);
        chk("rz_ctl1", {s_ready1, dl1, wr1, busy1, done1}, 0);
        chk("rz_dat1", {idx1, addr1, dout1}, 0);
        chk("rz_ext1", ext1, 0);
    endtask

    task automatic wait_writes(input int k, input int target, input string tag);
        int c;
        c = 0;
        while (c < 2000 && n_wr[k] < target) begin
            tick(1);
            c++;
        end
        chk(tag, n_wr[k] >= target, 1);
    endtask

    initial begin
        int b0, b1;
        #3;
        check_zero();
        tick(2);
        reset_n = 1'b1;
        tick(2);

        file_q = '{8'h11, 8'h22, 8'h33};
        start_file(16'h0001, 0);
        finish_file();

        file_q = '{8'hAA, 8'hBB, 8'hCC};
        start_file(16'h0007, 0);
        finish_file();

        // backpressure held long enough that both instances park in WRITE
        fill_random(4);
        b0 = n_wr[0];
        b1 = n_wr[1];
        start_file(16'h0003, 2);
        tick(30);
        chk("wait_no_wr0", n_wr[0] - b0, 0);
        chk("wait_no_wr1", n_wr[1] - b1, 0);
        wait_mode = 0;
        tick(1);
        chk("wait_release_wr0", wr0, 1);
        chk("wait_release_wr1", wr1, 1);
        finish_file();

        fill_random(6);
        start_file(16'h0002, 0);
        tick(6);
        chk("poke_busy", busy0 & busy1, 1);
        cmd_index = 16'h0005;
        cmd_ext = ~exp_ext;
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        finish_file();

        fill_random(12);
        start_file(16'h0009, 0);
        wait_writes(0, n_wr[0] + 2, "abort_reach");
        b0 = n_done[0] + n_done[1];
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_ctl0", {dl0, busy0, s_ready0, wr0}, 0);
        chk("abort_ctl1", {dl1, busy1, s_ready1, wr1}, 0);
        tick(GAP + TAIL + 5);
        chk("abort_no_done", n_done[0] + n_done[1] - b0, 0);
        clear_all();

        fill_random(5);
        start_file(16'h000A, 0);
        finish_file();

        for (int r = 0; r < 8; r++) begin
            fill_random($urandom_range(1, 9));
            start_file(16'($urandom), $urandom_range(1));
            finish_file();
        end

        fill_random(8);
        start_file(16'h0C0D, 0);
        wait_writes(0, n_wr[0] + 2, "reset_reach");
        #2;
        reset_n = 1'b0;
        #1;
        check_zero();
        clear_all();
        tick(2);
        reset_n = 1'b1;
        tick(2);

        fill_random(3);
        start_file(16'h0042, 1);
        finish_file();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
